// File: rtl/ts_gate_scheduler_if.sv
// Host-side bundle for the gate scheduler: time sync, config writes and gate outputs.
interface ts_gate_scheduler_if #(
    parameter int QUEUE_NUM = 8
);
    logic [47:0]          iv_sync_time;
    logic                 i_sync_time_wr;
    logic                 i_cfg_wr;
    logic [4:0]           iv_cfg_addr;
    logic [31:0]          iv_cfg_data;
    logic [QUEUE_NUM-1:0] ov_gate_state;
    logic [3:0]           ov_entry_idx;
    logic                 o_cycle_start;
    logic                 o_running;

    // Host / config block side.
    modport master (
        output iv_sync_time, i_sync_time_wr, i_cfg_wr, iv_cfg_addr, iv_cfg_data,
        input  ov_gate_state, ov_entry_idx, o_cycle_start, o_running
    );

    // Scheduler side.
    modport slave (
        input  iv_sync_time, i_sync_time_wr, i_cfg_wr, iv_cfg_addr, iv_cfg_data,
        output ov_gate_state, ov_entry_idx, o_cycle_start, o_running
    );
endinterface

// File: rtl/ts_gate_scheduler.sv
// Time-aware gate scheduler: local ns clock, base-time start and a cyclic gate
// control list driving per-queue gate-open bits to the egress arbiter.
module ts_gate_scheduler #(
    parameter int GCL_DEPTH = 8,
    parameter int QUEUE_NUM = 8,
    parameter int CLK_NS    = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    ts_gate_scheduler_if.slave bus
);

    localparam int          IDX_W     = (GCL_DEPTH > 1) ? $clog2(GCL_DEPTH) : 1;
    localparam logic [23:0] STEP      = 24'(CLK_NS);
    localparam logic [47:0] TIME_STEP = 48'(CLK_NS);
    localparam logic [4:0]  ADDR_CTRL = 5'd16;
    localparam logic [4:0]  ADDR_BLO  = 5'd17;
    localparam logic [4:0]  ADDR_BHI  = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BASE,
        S_RUN
    } state_e;

    state_e               state_q, state_d;
    logic [47:0]          time_q;
    logic                 enable_q;
    logic [3:0]           list_len_q;
    logic [47:0]          base_time_q;
    logic [QUEUE_NUM-1:0] mask_q     [GCL_DEPTH];
    logic [23:0]          interval_q [GCL_DEPTH];

    logic [QUEUE_NUM-1:0] gate_q, gate_d;
    logic [3:0]           idx_q, idx_d;
    logic                 cycle_start_q, cycle_start_d;
    logic                 running_q, running_d;
    logic [23:0]          remaining_q, remaining_d;

    logic                 load_en;
    logic [3:0]           load_idx;
    logic [23:0]          load_ival;

    // Config decode; a control write clearing enable takes effect on the
    // same edge so it beats an entry expiry landing there.
    logic       entry_wr, ctrl_wr, disable_now, last_entry;
    logic [4:0] eff_len;

    assign entry_wr    = bus.i_cfg_wr && (bus.iv_cfg_addr < 5'(GCL_DEPTH));
    assign ctrl_wr     = bus.i_cfg_wr && (bus.iv_cfg_addr == ADDR_CTRL);
    assign disable_now = !enable_q || (ctrl_wr && !bus.iv_cfg_data[0]);
    assign eff_len     = ((list_len_q == 4'd0) || ({1'b0, list_len_q} > 5'(GCL_DEPTH)))
                         ? 5'(GCL_DEPTH) : {1'b0, list_len_q};
    // ">=" so a list shortened below the active index wraps on this expiry.
    assign last_entry  = ({1'b0, idx_q} >= (eff_len - 5'd1));

    // Local nanosecond time: realigned by the sync strobe, otherwise free-running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            time_q <= '0;
        end else if (bus.i_sync_time_wr) begin
            time_q <= bus.iv_sync_time;
        end else begin
            time_q <= time_q + TIME_STEP;
        end
    end

    // Config registers and GCL storage.
    // NOTE: the GCL array is reset because a reset must lose the programmed list;
    // a memory with no reset requirement would be left out of the reset branch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            enable_q    <= 1'b0;
            list_len_q  <= '0;
            base_time_q <= '0;
            for (int i = 0; i < GCL_DEPTH; i++) begin
                mask_q[i]     <= '0;
                interval_q[i] <= '0;
            end
        end else begin
            if (entry_wr) begin
                mask_q[bus.iv_cfg_addr[IDX_W-1:0]]     <= bus.iv_cfg_data[24 +: QUEUE_NUM];
                interval_q[bus.iv_cfg_addr[IDX_W-1:0]] <= bus.iv_cfg_data[23:0];
            end
            if (ctrl_wr) begin
                enable_q   <= bus.iv_cfg_data[0];
                list_len_q <= bus.iv_cfg_data[4:1];
            end
            if (bus.i_cfg_wr && (bus.iv_cfg_addr == ADDR_BLO)) begin
                base_time_q[31:0] <= bus.iv_cfg_data;
            end
            if (bus.i_cfg_wr && (bus.iv_cfg_addr == ADDR_BHI)) begin
                base_time_q[47:32] <= bus.iv_cfg_data[15:0];
            end
        end
    end

    // Scheduler state and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            gate_q        <= '1;
            idx_q         <= '0;
            cycle_start_q <= 1'b0;
            running_q     <= 1'b0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            gate_q        <= gate_d;
            idx_q         <= idx_d;
            cycle_start_q <= cycle_start_d;
            running_q     <= running_d;
            remaining_q   <= remaining_d;
        end
    end

    // Next-state logic: base-time wait, entry countdown and list wrap.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        gate_d        = gate_q;
        idx_d         = idx_q;
        cycle_start_d = 1'b0;
        running_d     = running_q;
        remaining_d   = remaining_q;
        load_en       = 1'b0;
        load_idx      = '0;
        load_ival     = '0;

        if (disable_now) begin
            state_d   = S_IDLE;
            gate_d    = '1;
            idx_d     = '0;
            running_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    gate_d    = '1;
                    idx_d     = '0;
                    running_d = 1'b0;
                    state_d   = S_WAIT_BASE;
                end
                S_WAIT_BASE: begin
                    gate_d = '1;
                    // Pre-edge time, so a coincident sync load cannot mask a crossing.
                    if (time_q >= base_time_q) begin
                        state_d   = S_RUN;
                        running_d = 1'b1;
                        load_en   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (remaining_q <= STEP) begin
                        load_en  = 1'b1;
                        load_idx = last_entry ? 4'd0 : (idx_q + 4'd1);
                    end else begin
                        remaining_d = remaining_q - STEP;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (load_en) begin
            load_ival     = interval_q[load_idx[IDX_W-1:0]];
            gate_d        = mask_q[load_idx[IDX_W-1:0]];
            idx_d         = load_idx;
            cycle_start_d = (load_idx == 4'd0);
            remaining_d   = (load_ival < STEP) ? STEP : load_ival;
        end
    end

    assign bus.ov_gate_state = gate_q;
    assign bus.ov_entry_idx  = idx_q;
    assign bus.o_cycle_start = cycle_start_q;
    assign bus.o_running     = running_q;

endmodule
